frame_fifo_write: RTL and testbench
===================================

FRAME_FIFO_WRITE -- requirements
Module: frame_fifo_write

Interface
REQ-001 SHALL have parameters, one per line:
- MEM_DATA_BITS, 32, width of one memory word.
- ADDR_BITS, 21, memory word address width.
- BURST_BITS, 9, burst counter width.
- FIFO_DEPTH, 512, words in the upstream write FIFO.
- BURST_SIZE, 128, maximum words per burst.

REQ-002 SHALL have ports, one per line:
- mem_clk in 1: the single clock.
- rst_n in 1: reset, synchronous, active-low.
- Sdr_init_done in 1: SDRAM initialisation complete.
- Sdr_rd_busy in 1: the read stage holds the SDRAM.
- O_wr_busy out 1: write burst in progress.
- App_wr_en out 1: memory write strobe.
- App_wr_addr out ADDR_BITS: memory write address.
- App_wr_data out MEM_DATA_BITS: memory write data.
- fifo_rd_en out 1: pop the upstream FIFO.
- fifo_rd_data in MEM_DATA_BITS: FIFO data, valid 1 cycle after fifo_rd_en.
- rdusedw in 10: FIFO read-side used words.
- write_req in 1: asynchronous frame-write request, level.
- write_req_ack out 1: request acknowledge.
- write_finish out 1: frame written.
- write_addr_0..3 in ADDR_BITS each: frame base addresses.
- write_addr_index in 2: selects the base address.
- write_len in ADDR_BITS: frame length in words.
- fifo_aclr out 1: FIFO clear.

Function
REQ-003 SHALL pass write_req through 3 mem_clk flops, and write_len and write_addr_index through 2 flops each; only the synchronised copies are used internally.

REQ-004 SHALL implement states IDLE, ACK, CHECK_FIFO, WRITE_BURST, WRITE_BURST_END, END.

REQ-005 IDLE: SHALL go to ACK when synced req=1 and Sdr_init_done=1; write_req_ack=0.

REQ-006 ACK, while synced req=1:
- write_req_ack=1 and fifo_aclr=1.
- Latch write_len, set remaining=write_len.
- Load App_wr_addr from the base selected by the synced index.
- Clear the written-word counter.

REQ-007 ACK, when synced req=0: SHALL drop write_req_ack and fifo_aclr and go to CHECK_FIFO.

REQ-008 CHECK_FIFO:
- burst_len = min(BURST_SIZE, remaining).
- Synced req=1 SHALL go to ACK (priority).
- Otherwise go to WRITE_BURST when rdusedw >= burst_len and Sdr_rd_busy=0.
- Otherwise hold.

REQ-009 WRITE_BURST:
- fifo_rd_en SHALL be asserted for exactly burst_len consecutive cycles, starting the first cycle in state.
- App_wr_en SHALL be fifo_rd_en delayed 1 cycle, with App_wr_data=fifo_rd_data in the same cycle.

REQ-010 SHALL increment App_wr_addr by 1 on the cycle after each App_wr_en, wrapping modulo 2^ADDR_BITS.

REQ-011 SHALL leave WRITE_BURST for WRITE_BURST_END on the cycle after the last App_wr_en, and at that point subtract burst_len from remaining.

REQ-012 A write_req arriving during WRITE_BURST SHALL NOT abort the burst; it is serviced in WRITE_BURST_END.

REQ-013 WRITE_BURST_END SHALL go to:
- ACK if synced req=1;
- else CHECK_FIFO if remaining>0;
- else END.

REQ-014 END SHALL last 1 cycle, then go to IDLE; write_finish=1 only in END.

REQ-015 O_wr_busy SHALL equal (state==WRITE_BURST).

REQ-016 write_len=0 SHALL pass CHECK_FIFO->WRITE_BURST_END->END with no fifo_rd_en or App_wr_en.

REQ-017 Sdr_rd_busy rising mid-burst SHALL NOT interrupt the burst; it gates only burst start.

REQ-018 Illegal state encodings SHALL return to IDLE next cycle.

Reset
REQ-019 rst_n=0 at a mem_clk edge SHALL force, including mid-burst:
- state=IDLE.
- All outputs 0: App_wr_en, fifo_rd_en, App_wr_addr, App_wr_data, write_req_ack, write_finish, fifo_aclr, O_wr_busy.
- Synchroniser flops, counters and latches 0.

REQ-020 After reset, no FIFO pop or memory write SHALL occur until a new request completes ACK.

Verification
REQ-021 write_req=1 with index=2, write_addr_2=0x1000, write_len=256, rdusedw=300, then write_req dropped after ack -> 2 bursts of 128 App_wr_en; addresses 0x1000..0x10FF contiguous; write_finish pulses once.

REQ-022 write_len=200 -> bursts of 128 then 72; the second burst starts only when rdusedw>=72; 200 writes total.

REQ-023 In CHECK_FIFO with rdusedw=200 and Sdr_rd_busy=1 for 20 cycles -> no fifo_rd_en during those cycles; burst starts the cycle after Sdr_rd_busy falls.

REQ-024 write_req reasserted mid-burst -> the burst completes all 128 writes; then ACK, with the address reloaded and write_req_ack=1.

REQ-025 rst_n=0 at the 50th word of a burst -> next cycle all outputs 0 and state IDLE; no further App_wr_en.

REQ-026 write_addr=0x1FFF80 (21-bit) with write_len=256 -> address wraps to 0x000000 after 0x1FFFFF.

Source files
------------

// File: rtl/frame_fifo_write.sv
// Frame writer: drains the upstream FIFO into SDRAM in bursts.
// Each bursts is at most BURST_SIZE words, starting at a selectable base address.
module frame_fifo_write #(
   parameter int MEM_DATA_BITS = 32,
   parameter int ADDR_BITS     = 21,
   parameter int BURST_BITS    = 9,
   parameter int FIFO_DEPTH    = 512,
   parameter int BURST_SIZE    = 128
) (
   input  logic                     mem_clk,
   input  logic                     rst_n,
   input  logic                     Sdr_init_done,
   input  logic                     Sdr_rd_busy,
   output logic                     O_wr_busy,
   output logic                     App_wr_en,
   output logic [ADDR_BITS-1:0]     App_wr_addr,
   output logic [MEM_DATA_BITS-1:0] App_wr_data,
   output logic                     fifo_rd_en,
   input  logic [MEM_DATA_BITS-1:0] fifo_rd_data,
   input  logic [9:0]               rdusedw,
   input  logic                     write_req,
   output logic                     write_req_ack,
   output logic                     write_finish,
   input  logic [ADDR_BITS-1:0]     write_addr_0,
   input  logic [ADDR_BITS-1:0]     write_addr_1,
   input  logic [ADDR_BITS-1:0]     write_addr_2,
   input  logic [ADDR_BITS-1:0]     write_addr_3,
   input  logic [1:0]               write_addr_index,
   input  logic [ADDR_BITS-1:0]     write_len,
   output logic                     fifo_aclr
);

   // A burst can never be larger than what the FIFO is able to hold.
   localparam int BurstCap =
      (BURST_SIZE < FIFO_DEPTH) ? BURST_SIZE : FIFO_DEPTH;

   typedef enum logic [2:0] {
      IDLE            = 3'd0,
      ACK             = 3'd1,
      CHECK_FIFO      = 3'd2,
      WRITE_BURST     = 3'd3,
      WRITE_BURST_END = 3'd4,
      END             = 3'd5
   } state_t;

   state_t state, next_state;

   logic [2:0]            req_sync;
   logic [ADDR_BITS-1:0]  len_s1, len_s2;
   logic [1:0]            idx_s1, idx_s2;
   logic                  req;
   logic [ADDR_BITS-1:0]  remaining;
   logic [ADDR_BITS-1:0]  burst_len;
   logic [ADDR_BITS-1:0]  base_sel;
   logic [BURST_BITS-1:0] rd_cnt, wr_cnt;
   logic                  fifo_ok;
   logic                  burst_last;

   assign req = req_sync[2];

   always_ff @(posedge mem_clk) begin
      if (!rst_n) begin
         req_sync <= '0;
         len_s1   <= '0;
         len_s2   <= '0;
         idx_s1   <= '0;
         idx_s2   <= '0;
      end else begin
         req_sync <= {req_sync[1:0], write_req};
         len_s1   <= write_len;
         len_s2   <= len_s1;
         idx_s1   <= write_addr_index;
         idx_s2   <= idx_s1;
      end
   end

   always_comb begin
      burst_len = remaining;
      if (remaining > ADDR_BITS'(BurstCap))
         burst_len = ADDR_BITS'(BurstCap);
   end

   always_comb begin
      base_sel = write_addr_0;
      case (idx_s2)
         2'd1:    base_sel = write_addr_1;
         2'd2:    base_sel = write_addr_2;
         2'd3:    base_sel = write_addr_3;
         default: base_sel = write_addr_0;
      endcase
   end

   assign fifo_ok    = ADDR_BITS'(rdusedw) >= burst_len;
   assign burst_last = App_wr_en &&
      (ADDR_BITS'(wr_cnt) == burst_len - ADDR_BITS'(1));

   always_ff @(posedge mem_clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:
            if (req && Sdr_init_done) next_state = ACK;
         ACK:
            if (!req) next_state = CHECK_FIFO;
         CHECK_FIFO:
            if (req)
               next_state = ACK;
            else if (remaining == '0)
               next_state = WRITE_BURST_END;
            else if (fifo_ok && !Sdr_rd_busy)
               next_state = WRITE_BURST;
         WRITE_BURST:
            if (burst_last) next_state = WRITE_BURST_END;
         WRITE_BURST_END:
            if (req)
               next_state = ACK;
            else if (remaining != '0)
               next_state = CHECK_FIFO;
            else
               next_state = END;
         END:
            next_state = IDLE;
         default:
            next_state = IDLE;
      endcase
   end

   always_comb begin
      O_wr_busy     = (state == WRITE_BURST);
      fifo_rd_en    = (state == WRITE_BURST) &&
                      (ADDR_BITS'(rd_cnt) < burst_len);
      write_req_ack = (state == ACK) && req;
      fifo_aclr     = (state == ACK) && req;
      write_finish  = (state == END);
      App_wr_data   = App_wr_en ? fifo_rd_data : '0;
   end

   always_ff @(posedge mem_clk) begin
      if (!rst_n) begin
         App_wr_en   <= 1'b0;
         App_wr_addr <= '0;
         remaining   <= '0;
         rd_cnt      <= '0;
         wr_cnt      <= '0;
      end else begin
         App_wr_en <= fifo_rd_en;
         if (App_wr_en)
            App_wr_addr <= App_wr_addr + 1'b1;
         case (state)
            ACK:
               if (req) begin
                  remaining   <= len_s2;
                  App_wr_addr <= base_sel;
                  rd_cnt      <= '0;
                  wr_cnt      <= '0;
               end
            CHECK_FIFO: begin
               rd_cnt <= '0;
               wr_cnt <= '0;
            end
            WRITE_BURST: begin
               if (fifo_rd_en) rd_cnt <= rd_cnt + 1'b1;
               if (App_wr_en)  wr_cnt <= wr_cnt + 1'b1;
               if (burst_last) remaining <= remaining - burst_len;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_fifo_write.sv
// Bench for frame_fifo_write: queue-backed FIFO model plus
// expected write stream computed from base + i modulo 2^21.
module tb_frame_fifo_write;
   localparam int DW = 32;
   localparam int AW = 21;

   logic          mem_clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          Sdr_init_done = 1'b0;
   logic          Sdr_rd_busy = 1'b0;
   logic          O_wr_busy, App_wr_en, fifo_rd_en;
   logic [AW-1:0] App_wr_addr;
   logic [DW-1:0] App_wr_data;
   logic [DW-1:0] fifo_rd_data = '0;
   logic [9:0]    rdusedw = '0;
   logic          write_req = 1'b0;
   logic          write_req_ack, write_finish, fifo_aclr;
   logic [AW-1:0] write_addr_0 = '0, write_addr_1 = '0;
   logic [AW-1:0] write_addr_2 = '0, write_addr_3 = '0;
   logic [1:0]    write_addr_index = '0;
   logic [AW-1:0] write_len = '0;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] fifo_q[$], exp_q[$];
   logic [AW-1:0] wa_q[$];
   logic [DW-1:0] wd_q[$];
   int runs[$];
   int run_len = 0, fin_cnt = 0, pops = 0;

   frame_fifo_write dut (
      .mem_clk(mem_clk), .rst_n(rst_n),
      .Sdr_init_done(Sdr_init_done), .Sdr_rd_busy(Sdr_rd_busy),
      .O_wr_busy(O_wr_busy), .App_wr_en(App_wr_en),
      .App_wr_addr(App_wr_addr), .App_wr_data(App_wr_data),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
      .rdusedw(rdusedw), .write_req(write_req),
      .write_req_ack(write_req_ack), .write_finish(write_finish),
      .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
      .write_addr_2(write_addr_2), .write_addr_3(write_addr_3),
      .write_addr_index(write_addr_index), .write_len(write_len),
      .fifo_aclr(fifo_aclr)
   );

   always #5 mem_clk = ~mem_clk;

   // Show-ahead-free FIFO: data appears the cycle after the pop.
   always @(posedge mem_clk) begin
      if (fifo_rd_en) begin
         if (fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
         else                   fifo_rd_data <= 32'hDEAD_BEEF;
      end
   end

   always @(negedge mem_clk) begin
      if (App_wr_en) begin
         wa_q.push_back(App_wr_addr);
         wd_q.push_back(App_wr_data);
         run_len++;
      end else if (run_len > 0) begin
         runs.push_back(run_len);
         run_len = 0;
      end
      if (write_finish) fin_cnt++;
      if (fifo_rd_en) pops++;
   end

   task automatic clear_logs();
      wa_q.delete(); wd_q.delete(); runs.delete();
      fifo_q.delete(); exp_q.delete();
      run_len = 0; fin_cnt = 0; pops = 0;
   endtask

   task automatic fill(input int n);
      logic [DW-1:0] w;
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         fifo_q.push_back(w);
         exp_q.push_back(w);
      end
   endtask

   function automatic int first_bad(input logic [AW-1:0] base,
                                    input int start, input int n);
      logic [AW-1:0] ea;
      for (int i = 0; i < n; i++) begin
         if (start + i >= wa_q.size()) return i;
         ea = base + AW'(i);
         if (wa_q[start+i] !== ea) return i;
         if (wd_q[start+i] !== exp_q[start+i]) return i;
      end
      return -1;
   endfunction

   function automatic int run_at(input int k);
      if (k < runs.size()) return runs[k];
      return -1;
   endfunction

   task automatic request(input logic [1:0] idx, input int len,
                          output bit ok);
      ok = 1'b0;
      write_addr_index = idx;
      write_len = AW'(len);
      write_req = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge mem_clk);
         if (write_req_ack) begin ok = 1'b1; break; end
      end
      @(posedge mem_clk); #1;
      write_req = 1'b0;
   endtask

   task automatic wait_finish(input int maxc, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < maxc; c++) begin
         @(negedge mem_clk);
         if (write_finish) begin ok = 1'b1; break; end
      end
      repeat (3) @(negedge mem_clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      Sdr_init_done = 1'b1;
      repeat (3) @(posedge mem_clk);
      @(negedge mem_clk);
      tests++;
      if ({App_wr_en, fifo_rd_en, write_req_ack, write_finish,
           fifo_aclr, O_wr_busy} !== 6'b0) begin
         fails++;
         $display("FAIL reset_flags: got %b want 000000",
            {App_wr_en, fifo_rd_en, write_req_ack, write_finish,
             fifo_aclr, O_wr_busy});
      end
      tests++;
      if (App_wr_addr !== '0 || App_wr_data !== '0) begin
         fails++;
         $display("FAIL reset_bus: addr %h data %h want 0",
            App_wr_addr, App_wr_data);
      end
      @(posedge mem_clk); #1;
      rst_n = 1'b1;
      clear_logs();
      repeat (20) @(negedge mem_clk);
      tests++;
      if (pops !== 0) begin
         fails++;
         $display("FAIL idle_no_pop: got %0d want 0", pops);
      end
   endtask

   task automatic test_two_bursts();
      bit ok, ok2;
      int fb;
      clear_logs();
      fill(256);
      rdusedw = 10'd300;
      write_addr_2 = 21'h1000;
      request(2'd2, 256, ok);
      wait_finish(2000, ok2);
      tests++;
      if (!(ok && ok2)) begin
         fails++;
         $display("FAIL two_handshake: ack %0d fin %0d want 1 1", ok, ok2);
      end
      tests++;
      if (wa_q.size() !== 256 || pops !== 256) begin
         fails++;
         $display("FAIL two_count: writes %0d pops %0d want 256",
            wa_q.size(), pops);
      end
      fb = first_bad(21'h1000, 0, 256);
      tests++;
      if (fb !== -1) begin
         fails++;
         $display("FAIL two_stream: first bad word %0d want none", fb);
      end
      tests++;
      if (runs.size() !== 2 || run_at(0) !== 128 || run_at(1) !== 128) begin
         fails++;
         $display("FAIL two_bursts: n %0d r0 %0d r1 %0d want 2 128 128",
            runs.size(), run_at(0), run_at(1));
      end
      tests++;
      if (fin_cnt !== 1) begin
         fails++;
         $display("FAIL two_finish: got %0d want 1", fin_cnt);
      end
   endtask

   task automatic test_len200_gating();
      bit ok, ok2;
      int fb;
      clear_logs();
      fill(200);
      rdusedw = 10'd128;
      write_addr_0 = AW'($urandom);
      request(2'd0, 200, ok);
      for (int c = 0; c < 100; c++) begin
         @(negedge mem_clk);
         if (fifo_rd_en) break;
      end
      rdusedw = 10'd50;
      repeat (160) @(negedge mem_clk);
      tests++;
      if (wa_q.size() !== 128 || pops !== 128) begin
         fails++;
         $display("FAIL gate_first: writes %0d pops %0d want 128",
            wa_q.size(), pops);
      end
      rdusedw = 10'd71;
      repeat (10) @(negedge mem_clk);
      tests++;
      if (pops !== 128) begin
         fails++;
         $display("FAIL gate_71: pops %0d want 128", pops);
      end
      rdusedw = 10'd72;
      wait_finish(500, ok2);
      fb = first_bad(write_addr_0, 0, 200);
      tests++;
      if (!(ok && ok2) || wa_q.size() !== 200 || fb !== -1) begin
         fails++;
         $display("FAIL gate_stream: ok %0d%0d writes %0d bad %0d want 11 200 -1",
            ok, ok2, wa_q.size(), fb);
      end
      tests++;
      if (runs.size() !== 2 || run_at(0) !== 128 || run_at(1) !== 72) begin
         fails++;
         $display("FAIL gate_bursts: n %0d r0 %0d r1 %0d want 2 128 72",
            runs.size(), run_at(0), run_at(1));
      end
   endtask

   task automatic test_rd_busy();
      bit ok, ok2;
      int seen, fb;
      clear_logs();
      fill(100);
      rdusedw = 10'd200;
      Sdr_rd_busy = 1'b1;
      write_addr_1 = AW'($urandom);
      request(2'd1, 100, ok);
      for (int c = 0; c < 20; c++) begin
         @(negedge mem_clk);
         if (!write_req_ack) break;
      end
      seen = 0;
      repeat (20) begin
         @(negedge mem_clk);
         if (fifo_rd_en) seen++;
      end
      tests++;
      if (!ok || seen !== 0) begin
         fails++;
         $display("FAIL busy_hold: ack %0d pops %0d want 1 0", ok, seen);
      end
      @(posedge mem_clk); #1;
      Sdr_rd_busy = 1'b0;
      @(negedge mem_clk);
      tests++;
      if (fifo_rd_en !== 1'b0) begin
         fails++;
         $display("FAIL busy_early: rd_en %b want 0", fifo_rd_en);
      end
      @(negedge mem_clk);
      tests++;
      if (fifo_rd_en !== 1'b1 || O_wr_busy !== 1'b1) begin
         fails++;
         $display("FAIL busy_start: rd_en %b busy %b want 1 1",
            fifo_rd_en, O_wr_busy);
      end
      repeat (30) @(negedge mem_clk);
      Sdr_rd_busy = 1'b1;
      wait_finish(400, ok2);
      Sdr_rd_busy = 1'b0;
      fb = first_bad(write_addr_1, 0, 100);
      tests++;
      if (!ok2 || runs.size() !== 1 || run_at(0) !== 100 || fb !== -1) begin
         fails++;
         $display("FAIL busy_mid: fin %0d n %0d r0 %0d bad %0d want 1 1 100 -1",
            ok2, runs.size(), run_at(0), fb);
      end
   endtask

   task automatic test_reassert();
      bit ok, ok2, acked;
      int fb1, fb2;
      clear_logs();
      fill(256 + 64);
      rdusedw = 10'd511;
      write_addr_0 = 21'h2000;
      request(2'd0, 256, ok);
      for (int c = 0; c < 100; c++) begin
         @(negedge mem_clk);
         if (fifo_rd_en) break;
      end
      repeat (10) @(posedge mem_clk);
      #1;
      write_addr_1 = 21'h3000;
      write_addr_index = 2'd1;
      write_len = AW'(64);
      write_req = 1'b1;
      acked = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge mem_clk);
         if (write_req_ack) begin acked = 1'b1; break; end
      end
      tests++;
      if (!ok || !acked || wa_q.size() !== 128 || run_at(0) !== 128) begin
         fails++;
         $display("FAIL reack_burst: ack %0d%0d writes %0d r0 %0d want 11 128 128",
            ok, acked, wa_q.size(), run_at(0));
      end
      @(negedge mem_clk);
      tests++;
      if (App_wr_addr !== 21'h3000 || write_req_ack !== 1'b1) begin
         fails++;
         $display("FAIL reack_addr: addr %h ack %b want 003000 1",
            App_wr_addr, write_req_ack);
      end
      @(posedge mem_clk); #1;
      write_req = 1'b0;
      wait_finish(600, ok2);
      fb1 = first_bad(21'h2000, 0, 128);
      fb2 = first_bad(21'h3000, 128, 64);
      tests++;
      if (!ok2 || wa_q.size() !== 192 || fb1 !== -1 || fb2 !== -1 ||
          run_at(1) !== 64) begin
         fails++;
         $display("FAIL reack_stream: fin %0d writes %0d bad %0d %0d r1 %0d want 1 192 -1 -1 64",
            ok2, wa_q.size(), fb1, fb2, run_at(1));
      end
   endtask

   task automatic test_wrap();
      bit ok, ok2;
      int fb;
      clear_logs();
      fill(256);
      rdusedw = 10'd511;
      write_addr_3 = 21'h1FFF80;
      request(2'd3, 256, ok);
      wait_finish(2000, ok2);
      fb = first_bad(21'h1FFF80, 0, 256);
      tests++;
      if (!(ok && ok2) || wa_q.size() !== 256 || fb !== -1) begin
         fails++;
         $display("FAIL wrap_stream: ok %0d%0d writes %0d bad %0d want 11 256 -1",
            ok, ok2, wa_q.size(), fb);
      end
      tests++;
      if (wa_q.size() < 129 || wa_q[127] !== 21'h1FFFFF ||
          wa_q[128] !== 21'h000000) begin
         fails++;
         $display("FAIL wrap_edge: size %0d want 0x1FFFFF then 0x000000",
            wa_q.size());
      end
   endtask

   task automatic test_zero_len();
      bit ok, ok2;
      clear_logs();
      request(2'd0, 0, ok);
      wait_finish(100, ok2);
      tests++;
      if (!(ok && ok2) || pops !== 0 || wa_q.size() !== 0 ||
          fin_cnt !== 1) begin
         fails++;
         $display("FAIL zero_len: ok %0d%0d pops %0d writes %0d fin %0d want 11 0 0 1",
            ok, ok2, pops, wa_q.size(), fin_cnt);
      end
   endtask

   task automatic test_random();
      bit ok, ok2;
      int len, fb, nb;
      logic [1:0] idx;
      logic [AW-1:0] base;
      for (int it = 0; it < 3; it++) begin
         clear_logs();
         len = $urandom_range(1, 300);
         idx = 2'($urandom_range(0, 3));
         write_addr_0 = AW'($urandom);
         write_addr_1 = AW'($urandom);
         write_addr_2 = AW'($urandom);
         write_addr_3 = AW'($urandom);
         case (idx)
            2'd0: base = write_addr_0;
            2'd1: base = write_addr_1;
            2'd2: base = write_addr_2;
            default: base = write_addr_3;
         endcase
         fill(len);
         rdusedw = 10'd511;
         request(idx, len, ok);
         wait_finish(2000, ok2);
         fb = first_bad(base, 0, len);
         nb = (len + 127) / 128;
         tests++;
         if (!(ok && ok2) || wa_q.size() !== len || fb !== -1 ||
             runs.size() !== nb) begin
            fails++;
            $display("FAIL random_%0d: len %0d writes %0d bad %0d bursts %0d want %0d",
               it, len, wa_q.size(), fb, runs.size(), nb);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n;
      clear_logs();
      fill(256);
      rdusedw = 10'd511;
      write_addr_3 = AW'($urandom);
      request(2'd3, 256, ok);
      n = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge mem_clk);
         if (App_wr_en) n++;
         if (n == 50) break;
      end
      rst_n = 1'b0;
      @(negedge mem_clk);
      tests++;
      if ({App_wr_en, fifo_rd_en, write_req_ack, write_finish,
           fifo_aclr, O_wr_busy} !== 6'b0 ||
          App_wr_addr !== '0 || App_wr_data !== '0) begin
         fails++;
         $display("FAIL midreset_out: flags %b addr %h data %h want 0",
            {App_wr_en, fifo_rd_en, write_req_ack, write_finish,
             fifo_aclr, O_wr_busy}, App_wr_addr, App_wr_data);
      end
      tests++;
      if (!ok || wa_q.size() !== 50) begin
         fails++;
         $display("FAIL midreset_count: ack %0d writes %0d want 1 50",
            ok, wa_q.size());
      end
      @(posedge mem_clk); #1;
      rst_n = 1'b1;
      clear_logs();
      repeat (300) @(negedge mem_clk);
      tests++;
      if (wa_q.size() !== 0 || pops !== 0) begin
         fails++;
         $display("FAIL midreset_quiet: writes %0d pops %0d want 0 0",
            wa_q.size(), pops);
      end
   endtask

   initial begin
      test_reset();
      test_two_bursts();
      test_len200_gating();
      test_rd_busy();
      test_reassert();
      test_wrap();
      test_zero_len();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
